// File: rtl/noc_pkg.sv
// Shared flit-format helpers, FIFO state encoding and counter widths for the NoC NI.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package noc_pkg;

    localparam int MisrouteCntWidth = 16;

    typedef enum logic [1:0] {
        FifoEmpty   = 2'd0,
        FifoPartial = 2'd1,
        FifoFull    = 2'd2
    } fifoState_t;

    // Destination field occupies the top AddrWidth bits of the flit.
    function automatic int destMsb(input int dataWidth);
        return dataWidth - 1;
    endfunction

    function automatic int destLsb(input int dataWidth, input int addrWidth);
        return dataWidth - addrWidth;
    endfunction

    // Payload is everything below the destination field.
    function automatic int payloadWidth(input int dataWidth, input int addrWidth);
        return dataWidth - addrWidth;
    endfunction

endpackage

// File: rtl/ni_fifo.sv
// Generic first-word-fall-through FIFO with EMPTY/PARTIAL/FULL state tracking.
// Latency: 1 cycle from push to head valid; no same-cycle bypass when empty.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module ni_fifo
    import noc_pkg::*;
#(
    parameter int Width = 32,
    parameter int Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] pushData,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PtrWidth = $clog2(Depth);
    localparam logic [PtrWidth:0] LastCount = (PtrWidth+1)'(Depth - 1);
    localparam logic [PtrWidth:0] OneCount  = (PtrWidth+1)'(1);

    logic [Width-1:0]    mem [Depth];
    logic [PtrWidth-1:0] wrPtr;
    logic [PtrWidth-1:0] rdPtr;
    logic [PtrWidth:0]   count;
    fifoState_t          state;
    logic                doPush;
    logic                doPop;

    assign full   = (state == FifoFull);
    assign empty  = (state == FifoEmpty);
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    // Head is forced to zero while empty so outputs read 0 out of reset.
    assign head   = empty ? '0 : mem[rdPtr];

    // Storage array; contents are don't-care until the matching count says valid.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointers, occupancy count and the EMPTY/PARTIAL/FULL state machine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            state <= FifoEmpty;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (doPush && !doPop) begin
                count <= count + 1'b1;
            end else if (doPop && !doPush) begin
                count <= count - 1'b1;
            end
            case (state)
                FifoEmpty: begin
                    if (doPush) begin
                        state <= FifoPartial;
                    end
                end
                FifoPartial: begin
                    if (doPush && !doPop && count == LastCount) begin
                        state <= FifoFull;
                    end else if (doPop && !doPush && count == OneCount) begin
                        state <= FifoEmpty;
                    end
                end
                FifoFull: begin
                    if (doPop && !doPush) begin
                        state <= FifoPartial;
                    end
                end
                default: state <= FifoEmpty;
            endcase
        end
    end

endmodule

// File: rtl/noc_pe_interface.sv
// PE-to-switch network interface: packs/unpacks single-flit packets, drops misrouted RX flits.
// Latency: 1 cycle each direction; optional misroute counter under NOC_NI_MISROUTE_CNT_EN.
// Backpressure: ready = !full, or full with a same-cycle pop; misroutes are always consumed.
module noc_pe_interface
    import noc_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 4,
    parameter int MyAddr    = 0,
    parameter int TxDepth   = 4,
    parameter int RxDepth   = 2
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [DataWidth-AddrWidth-1:0] i_pe_data,
    input  logic [AddrWidth-1:0]           i_pe_dest,
    input  logic                           i_pe_data_valid,
    output logic                           o_pe_data_ready,
    output logic [DataWidth-1:0]           o_data,
    output logic                           o_data_valid,
    input  logic                           i_data_ready,
    input  logic [DataWidth-1:0]           i_data,
    input  logic                           i_data_valid,
    output logic                           o_data_ready,
    output logic [DataWidth-AddrWidth-1:0] o_pe_data,
    output logic                           o_pe_data_valid,
    input  logic                           i_pe_data_ready
`ifdef NOC_NI_MISROUTE_CNT_EN
    ,
    output logic [MisrouteCntWidth-1:0]    o_misroute_cnt
`endif
);

    localparam int PayloadWidth = payloadWidth(DataWidth, AddrWidth);
    localparam int DestMsb      = destMsb(DataWidth);
    localparam int DestLsb      = destLsb(DataWidth, AddrWidth);
    localparam logic [AddrWidth-1:0] OwnAddr = AddrWidth'(MyAddr);

    logic                    readyEn;
    logic                    txFull;
    logic                    txEmpty;
    logic                    txPush;
    logic                    txPop;
    logic                    rxFull;
    logic                    rxEmpty;
    logic                    rxPush;
    logic                    rxPop;
    logic                    rxAccept;
    logic                    rxHit;
    logic [AddrWidth-1:0]    rxDest;

    // Holds both readies low through reset and releases them on the first edge after.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            readyEn <= 1'b0;
        end else begin
            readyEn <= 1'b1;
        end
    end

    // Transmit path: loopback destinations go out to the network like any other.
    assign txPop           = !txEmpty && i_data_ready;
    assign o_pe_data_ready = readyEn && (!txFull || txPop);
    assign txPush          = i_pe_data_valid && o_pe_data_ready;
    assign o_data_valid    = !txEmpty;

    ni_fifo #(
        .Width (DataWidth),
        .Depth (TxDepth)
    ) txFifo (
        .clk      (i_clk),
        .rst      (i_reset),
        .push     (txPush),
        .pushData ({i_pe_dest, i_pe_data}),
        .pop      (txPop),
        .head     (o_data),
        .full     (txFull),
        .empty    (txEmpty)
    );

    // Receive path: every accepted flit is consumed, only own-address flits are kept.
    assign rxPop           = !rxEmpty && i_pe_data_ready;
    assign o_data_ready    = readyEn && (!rxFull || rxPop);
    assign rxAccept        = i_data_valid && o_data_ready;
    assign rxDest          = i_data[DestMsb:DestLsb];
    assign rxHit           = (rxDest == OwnAddr);
    assign rxPush          = rxAccept && rxHit;
    assign o_pe_data_valid = !rxEmpty;

    ni_fifo #(
        .Width (PayloadWidth),
        .Depth (RxDepth)
    ) rxFifo (
        .clk      (i_clk),
        .rst      (i_reset),
        .push     (rxPush),
        .pushData (i_data[PayloadWidth-1:0]),
        .pop      (rxPop),
        .head     (o_pe_data),
        .full     (rxFull),
        .empty    (rxEmpty)
    );

`ifdef NOC_NI_MISROUTE_CNT_EN
    logic                        misroute;
    logic [MisrouteCntWidth-1:0] misrouteCnt;

    assign misroute       = rxAccept && !rxHit;
    assign o_misroute_cnt = misrouteCnt;

    // Saturating count of flits dropped for carrying a foreign destination.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            misrouteCnt <= '0;
        end else if (misroute && misrouteCnt != '1) begin
            misrouteCnt <= misrouteCnt + 1'b1;
        end
    end
`else
    // Misrouted flits are consumed by the handshake above and simply not stored.
`endif

endmodule

// File: tb/tb_noc_pe_interface.sv
module tb_noc_pe_interface;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int PW = DW - AW;
    localparam logic [AW-1:0] OWN = 4'd3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] peData = '0;
    logic [AW-1:0] peDest = '0;
    logic          peValid = 1'b0;
    logic          peReadyOut;
    logic [DW-1:0] netDataOut;
    logic          netValidOut;
    logic          netReady = 1'b0;
    logic [DW-1:0] netData = '0;
    logic          netValid = 1'b0;
    logic          netReadyOut;
    logic [PW-1:0] peDataOut;
    logic          peValidOut;
    logic          peReady = 1'b0;
`ifdef NOC_NI_MISROUTE_CNT_EN
    logic [15:0]   misCnt;
`endif

    int nCompared = 0;
    int nMismatched = 0;
    logic [DW-1:0] txQ[$];
    logic [PW-1:0] rxQ[$];

    always #5 clk = ~clk;

    noc_pe_interface #(
        .DataWidth (DW),
        .AddrWidth (AW),
        .MyAddr    (3),
        .TxDepth   (4),
        .RxDepth   (2)
    ) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_pe_data       (peData),
        .i_pe_dest       (peDest),
        .i_pe_data_valid (peValid),
        .o_pe_data_ready (peReadyOut),
        .o_data          (netDataOut),
        .o_data_valid    (netValidOut),
        .i_data_ready    (netReady),
        .i_data          (netData),
        .i_data_valid    (netValid),
        .o_data_ready    (netReadyOut),
        .o_pe_data       (peDataOut),
        .o_pe_data_valid (peValidOut),
        .i_pe_data_ready (peReady)
`ifdef NOC_NI_MISROUTE_CNT_EN
        ,
        .o_misroute_cnt  (misCnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: inputs are stable from posedge+1 to the next posedge, so the
    // handshakes that will complete at the coming edge are visible at negedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (netValidOut && netReady) begin
                if (txQ.size() == 0) check("tx_unexpected_flit", netDataOut, 32'hxxxxxxxx);
                else check("tx_flit", netDataOut, txQ.pop_front());
            end
            if (peValidOut && peReady) begin
                if (rxQ.size() == 0) check("rx_unexpected_payload", 32'(peDataOut), 32'hxxxxxxxx);
                else check("rx_payload", 32'(peDataOut), 32'(rxQ.pop_front()));
            end
            if (peValid && peReadyOut) txQ.push_back({peDest, peData});
            if (netValid && netReadyOut && netData[DW-1:DW-AW] == OWN) rxQ.push_back(netData[PW-1:0]);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          peValid;
        logic [AW-1:0] dest;
        logic [PW-1:0] payload;
        logic          netReady;
        logic          netValid;
        logic [DW-1:0] netData;
        logic          peReady;
        logic          expPeReady;
        logic          expTxValid;
        logic          expRxReady;
        logic          expRxValid;
    } vec_t;

    vec_t vecs[19];

    task automatic drive(input vec_t v);
        peValid  = v.peValid;
        peDest   = v.dest;
        peData   = v.payload;
        netReady = v.netReady;
        netValid = v.netValid;
        netData  = v.netData;
        peReady  = v.peReady;
    endtask

    initial begin
        //            pv dest payload      nr nv netData       pr   ePR eTV eRR eRV
        vecs[0]  = '{0, 4'd0, 28'h0,       0, 0, 32'h0,        0,   1, 0, 1, 0};
        vecs[1]  = '{1, 4'd5, 28'h0ABCDEF, 1, 0, 32'h0,        0,   1, 0, 1, 0};
        vecs[2]  = '{0, 4'd0, 28'h0,       1, 0, 32'h0,        0,   1, 1, 1, 0};
        vecs[3]  = '{0, 4'd0, 28'h0,       1, 0, 32'h0,        0,   1, 0, 1, 0};
        vecs[4]  = '{0, 4'd0, 28'h0,       0, 1, 32'h3000_0042, 0,  1, 0, 1, 0};
        vecs[5]  = '{0, 4'd0, 28'h0,       0, 0, 32'h0,        0,   1, 0, 1, 1};
        vecs[6]  = '{0, 4'd0, 28'h0,       0, 1, 32'h3000_0043, 0,  1, 0, 1, 1};
        vecs[7]  = '{0, 4'd0, 28'h0,       0, 0, 32'h0,        0,   1, 0, 0, 1};
        vecs[8]  = '{0, 4'd0, 28'h0,       0, 1, 32'h3000_0044, 1,  1, 0, 1, 1};
        vecs[9]  = '{0, 4'd0, 28'h0,       0, 0, 32'h0,        0,   1, 0, 0, 1};
        vecs[10] = '{0, 4'd0, 28'h0,       0, 0, 32'h0,        1,   1, 0, 1, 1};
        vecs[11] = '{0, 4'd0, 28'h0,       0, 0, 32'h0,        1,   1, 0, 1, 1};
        vecs[12] = '{0, 4'd0, 28'h0,       0, 1, 32'h7000_0001, 1,  1, 0, 1, 0};
        vecs[13] = '{0, 4'd0, 28'h0,       0, 1, 32'h7000_0001, 1,  1, 0, 1, 0};
        vecs[14] = '{0, 4'd0, 28'h0,       0, 1, 32'h7000_0001, 1,  1, 0, 1, 0};
        vecs[15] = '{0, 4'd0, 28'h0,       0, 0, 32'h0,        1,   1, 0, 1, 0};
        vecs[16] = '{1, 4'd3, 28'h1234567, 1, 0, 32'h0,        0,   1, 0, 1, 0};
        vecs[17] = '{0, 4'd0, 28'h0,       1, 0, 32'h0,        0,   1, 1, 1, 0};
        vecs[18] = '{0, 4'd0, 28'h0,       1, 0, 32'h0,        0,   1, 0, 1, 0};

        // Reset state: every output low while reset is held.
        @(negedge clk);
        check("rst_pe_ready", peReadyOut, 0);
        check("rst_net_ready", netReadyOut, 0);
        check("rst_tx_valid", netValidOut, 0);
        check("rst_tx_data", netDataOut, 0);
        check("rst_rx_valid", peValidOut, 0);
        check("rst_rx_data", 32'(peDataOut), 0);
        rst = 1'b0;
        #1;
        check("rel_pe_ready_before_edge", peReadyOut, 0);
        check("rel_net_ready_before_edge", netReadyOut, 0);
        @(negedge clk);
        check("rel_pe_ready", peReadyOut, 1);
        check("rel_net_ready", netReadyOut, 1);

        // Table: single TX flit, RX own address, RX full push+pop, misroutes, loopback.
        for (int i = 0; i < 19; i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            @(negedge clk);
            check($sformatf("vec%0d_pe_ready", i), peReadyOut, vecs[i].expPeReady);
            check($sformatf("vec%0d_tx_valid", i), netValidOut, vecs[i].expTxValid);
            check($sformatf("vec%0d_net_ready", i), netReadyOut, vecs[i].expRxReady);
            check($sformatf("vec%0d_rx_valid", i), peValidOut, vecs[i].expRxValid);
        end
`ifdef NOC_NI_MISROUTE_CNT_EN
        check("misroute_cnt", misCnt, 3);
`endif

        // TX backpressure: 5 pushes into a depth-4 FIFO with the switch stalled.
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            netReady = 1'b0;
            netValid = 1'b0;
            peReady  = 1'b0;
            peValid  = 1'b1;
            peDest   = AW'(k + 1);
            peData   = PW'(28'h100 + k);
            @(negedge clk);
            check($sformatf("bp_ready_%0d", k), peReadyOut, (k < 4) ? 1 : 0);
        end
        @(posedge clk);
        #1;
        netReady = 1'b1;
        @(negedge clk);
        check("bp_release_valid", netValidOut, 1);
        check("bp_full_pop_ready", peReadyOut, 1);
        @(posedge clk);
        #1;
        peValid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check($sformatf("bp_drain_%0d", j), netValidOut, 1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("bp_drained", netValidOut, 0);

        // Reset mid-stream with two TX flits queued.
        @(posedge clk);
        #1;
        netReady = 1'b0;
        peValid  = 1'b1;
        peDest   = 4'd9;
        peData   = 28'h00000AA;
        @(posedge clk);
        #1;
        peData = 28'h00000BB;
        @(posedge clk);
        #1;
        peValid = 1'b0;
        @(negedge clk);
        check("mid_queued_valid", netValidOut, 1);
        #2;
        rst = 1'b1;
        txQ.delete();
        rxQ.delete();
        #1;
        check("mid_async_valid", netValidOut, 0);
        check("mid_async_data", netDataOut, 0);
        check("mid_async_pe_ready", peReadyOut, 0);
        check("mid_async_net_ready", netReadyOut, 0);
`ifdef NOC_NI_MISROUTE_CNT_EN
        check("mid_misroute_cnt", misCnt, 0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        netReady = 1'b1;
        @(negedge clk);
        check("post_pe_ready", peReadyOut, 1);
        check("post_net_ready", netReadyOut, 1);
        check("post_tx_valid", netValidOut, 0);
        check("post_rx_valid", peValidOut, 0);

        repeat (3) @(negedge clk);
        check("tx_queue_empty", txQ.size(), 0);
        check("rx_queue_empty", rxQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
